instr_fetch: RTL and testbench

Instruction fetch controller sitting directly upstream of the `program_counter` register. It reads the current PC, issues a valid/ready request to instruction memory, holds the returned word in an instruction register for decode, and drives `PCin`/`updPC` (here `pc_next`/`upd_pc`) with the sequential or redirected next PC. Branch/jump redirects from execute take priority and squash in-flight work.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 33 +++
 rtl/fetch_next_pc.sv | 52 +++++
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch controller.
//   fetch_state_e : fetch FSM state encoding
//   PC_INC        : sequential PC increment (one 32-bit word)
//   TRAP_VEC      : PC loaded on a misaligned redirect when the
//                   FETCH_MISALIGN_TRAP_EN build option is defined
//   align_pc()    : clears the two low address bits
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bus bundle between the fetch controller, instruction memory and decode.
//   imem_req_valid/imem_req_ready/imem_addr : memory request channel
//   imem_rsp_valid/imem_rsp_data            : memory response (no backpressure)
//   ir_valid/ir_ready/ir_data/ir_pc         : instruction register to decode
// Modports:
//   master : the fetch controller
//   slave  : the environment (memory + decode)
// -----------------------------------------------------------------------------
interface instr_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;

  modport master (
    output imem_req_valid, imem_addr, ir_valid, ir_data, ir_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, ir_valid, ir_data, ir_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, ir_ready
  );

endinterface

// File: rtl/fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC mux for the program counter register.
//   state        in  : current fetch FSM state
//   pc_in        in  : current PC
//   ir_fire      in  : decode accepted the instruction register this cycle
//   redirect     in  : branch/jump redirect from execute
//   redirect_pc  in  : redirect target
//   pc_next      out : next PC (equals pc_in when no update)
//   upd_pc       out : PC load strobe
//   misalign_err out : misaligned redirect (FETCH_MISALIGN_TRAP_EN builds only)
// Build option: FETCH_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VEC;
// otherwise the target is force-aligned and misalign_err stays 0.
// -----------------------------------------------------------------------------
module fetch_next_pc
  import fetch_pkg::*;
(
  input  fetch_state_e state,
  input  logic [31:0]  pc_in,
  input  logic         ir_fire,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output logic [31:0]  pc_next,
  output logic         upd_pc,
  output logic         misalign_err
);

  always_comb begin
    pc_next      = pc_in;
    upd_pc       = 1'b0;
    misalign_err = 1'b0;
    // Redirect wins over a sequential step; it is ignored only in IDLE.
    // ir_fire can never coincide with it because ir_valid is masked by redirect.
    if (redirect && (state != ST_IDLE)) begin
      upd_pc = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        pc_next      = TRAP_VEC;
        misalign_err = 1'b1;
      end else begin
        pc_next = redirect_pc;
      end
`else
      pc_next = align_pc(redirect_pc);
`endif
    end else if (ir_fire) begin
      upd_pc  = 1'b1;
      pc_next = pc_in + PC_INC;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch controller upstream of the program counter register.
// Requests the word at pc_in, holds the response in the instruction register
// for decode, and steps or redirects the PC.
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low reset
//   pc_in        in  : current PC from the program counter
//   pc_next      out : next PC to the program counter
//   upd_pc       out : one-cycle PC load strobe
//   bus          mst : memory request/response and decode channels
//   redirect     in  : branch/jump redirect from execute
//   redirect_pc  in  : redirect target
//   misalign_err out : misaligned redirect pulse (FETCH_MISALIGN_TRAP_EN only)
//   fetch_cnt    out : instructions accepted by decode, wraps at 2^32
// Build option: FETCH_MISALIGN_TRAP_EN (see fetch_next_pc).
// -----------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          pc_in,
  output logic [31:0]          pc_next,
  output logic                 upd_pc,
  instr_fetch_if.master        bus,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 misalign_err,
  output logic [31:0]          fetch_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  ir_data_q, ir_data_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic [31:0]  fetch_cnt_q, fetch_cnt_d;
  logic         req_valid;
  logic         ir_valid;
  logic         ir_fire;

  always_comb begin
    state_d     = state_q;
    ir_data_d   = ir_data_q;
    ir_pc_d     = ir_pc_q;
    fetch_cnt_d = fetch_cnt_q;
    req_valid   = 1'b0;
    ir_valid    = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // A redirect suppresses the request; the PC moves and we retry next cycle.
        req_valid = !redirect;
        if (req_valid && bus.imem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          // A response arriving in the redirect cycle is the stale one: drop it.
          state_d = bus.imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (bus.imem_rsp_valid) begin
          ir_data_d = bus.imem_rsp_data;
          ir_pc_d   = pc_in;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        ir_valid = !redirect;
        if (redirect) begin
          state_d = ST_REQ;
        end else if (bus.ir_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // Wait out the squashed request's response before issuing a new one.
        if (bus.imem_rsp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ir_fire = ir_valid && bus.ir_ready;

  fetch_next_pc u_next_pc (
    .state        (state_q),
    .pc_in        (pc_in),
    .ir_fire      (ir_fire),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pc_next      (pc_next),
    .upd_pc       (upd_pc),
    .misalign_err (misalign_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ir_data_q   <= 32'd0;
      ir_pc_q     <= 32'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      ir_data_q   <= ir_data_d;
      ir_pc_q     <= ir_pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_in;
  assign bus.ir_valid       = ir_valid;
  assign bus.ir_data        = ir_data_q;
  assign bus.ir_pc          = ir_pc_q;
  assign fetch_cnt          = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch: a driver models the program counter register and a
// variable-latency instruction memory and issues random decode stalls and
// redirects; redirect targets go into a queue that a separate monitor pops to
// check the PC update, while the monitor's own model of the architectural
// instruction stream checks every word presented to decode.
// Build option: FETCH_MISALIGN_TRAP_EN selects the trap expectations.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in, pc_next, redirect_pc, fetch_cnt;
  logic        upd_pc, redirect, misalign_err;

  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_in        (pc_in),
    .pc_next      (pc_next),
    .upd_pc       (upd_pc),
    .bus          (bus.master),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) return 32'h0000_0100;
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic logic exp_mis(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00);
`else
    return (t == 32'hDEAD_BEEF) && (t != 32'hDEAD_BEEF);
`endif
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(7))
      0:       return 32'h0000_0040;
      1:       return 32'h0000_0080;
      2:       return 32'h0000_0042;
      3:       return 32'hFFFF_FFF8;
      4:       return 32'($urandom_range(1023)) & ~32'h3;
      5:       return 32'($urandom_range(1023)) | 32'h1;
      default: return $urandom & 32'h0000_0FFF;
    endcase
  endfunction

  logic [31:0] redir_q[$];

  // Environment state: program counter register and single-outstanding memory.
  logic [31:0] pc_reg;
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic [31:0] req_log[$];
  bit          rand_mode;
  int          rel_cycles;
  bit          last_upd;

  task automatic cycle();
    @(negedge clk);
    pc_in = pc_reg;
    if (pend && pend_cnt == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    if (rand_mode) begin
      bus.imem_req_ready = ($urandom_range(3) != 0);
      bus.ir_ready       = ($urandom_range(9) < 7);
      redirect           = (rel_cycles >= 1) && ($urandom_range(9) == 0);
      redirect_pc        = pick_target();
    end else begin
      bus.imem_req_ready = 1'b1;
      bus.ir_ready       = 1'b1;
      redirect           = 1'b0;
      redirect_pc        = 32'd0;
    end
    if (redirect) redir_q.push_back(redirect_pc);
    #1;
    if (bus.imem_rsp_valid) pend = 1'b0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = bus.imem_addr;
      pend_cnt  = rand_mode ? int'($urandom_range(3)) : 0;
      req_log.push_back(bus.imem_addr);
    end
    last_upd = upd_pc;
    if (upd_pc) pc_reg = pc_next;
    rel_cycles++;
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst_n              = 1'b0;
    redirect           = 1'b0;
    redirect_pc        = 32'd0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.imem_req_ready = 1'b0;
    bus.ir_ready       = 1'b0;
    pend               = 1'b0;
    pc_reg             = 32'd0;
    pc_in              = 32'd0;
    if (check) begin
      #1;
      chk("rst_upd_pc", 32'(upd_pc), 32'd0);
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      chk("rst_fetch_cnt", fetch_cnt, 32'd0);
      chk("rst_ir_data", bus.ir_data, 32'd0);
      chk("rst_ir_pc", bus.ir_pc, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    rel_cycles = 0;
  endtask

  // Monitor: architectural model of the instruction stream seen by decode.
  initial begin
    logic [31:0] arch_pc, mcnt, t, e, prev_data;
    int          idle;
    bit          prev_hold;
    arch_pc = 0; mcnt = 0; idle = 0; prev_hold = 0; prev_data = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        arch_pc = 0; mcnt = 0; idle = 0; prev_hold = 0;
        redir_q.delete();
      end else begin
        idle++;
        if (redir_q.size() > 0) begin
          t = redir_q.pop_front();
          e = exp_target(t);
          chk("redir_upd_pc", 32'(upd_pc), 32'd1);
          chk("redir_pc_next", pc_next, e);
          chk("redir_misalign", 32'(misalign_err), 32'(exp_mis(t)));
          chk("redir_ir_valid", 32'(bus.ir_valid), 32'd0);
          arch_pc   = e;
          idle      = 0;
          prev_hold = 0;
        end else begin
          chk("misalign_idle", 32'(misalign_err), 32'd0);
          if (prev_hold) begin
            chk("hold_ir_valid", 32'(bus.ir_valid), 32'd1);
            chk("hold_ir_data", bus.ir_data, prev_data);
          end
          if (bus.ir_valid) begin
            chk("ir_pc", bus.ir_pc, arch_pc);
            chk("ir_data", bus.ir_data, mem_word(arch_pc));
            chk("no_req_in_hold", 32'(bus.imem_req_valid), 32'd0);
          end
          if (bus.ir_valid && bus.ir_ready) begin
            chk("acc_upd_pc", 32'(upd_pc), 32'd1);
            chk("acc_pc_next", pc_next, arch_pc + 32'd4);
            chk("fetch_cnt", fetch_cnt, mcnt);
            arch_pc = arch_pc + 32'd4;
            mcnt    = mcnt + 32'd1;
            idle    = 0;
          end else begin
            chk("no_upd_pc", 32'(upd_pc), 32'd0);
            chk("pc_next_passthru", pc_next, pc_in);
          end
          prev_hold = bus.ir_valid && !bus.ir_ready;
          prev_data = bus.ir_data;
        end
        if (idle > 80) begin
          chk("progress_timeout", 32'(idle), 32'd0);
          idle = 0;
        end
      end
    end
  end

  initial begin
    logic [8:0] upd_mask;
    int         k;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; pc_in = 32'd0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'd0; bus.ir_ready = 1'b0;
    pc_reg = 0; pend = 0; pend_cnt = 0; pend_addr = 0;
    rand_mode = 0; rel_cycles = 0; last_upd = 0;

    // Zero-wait memory, decode always ready: 3 cycles per instruction.
    do_reset(1'b1);
    req_log.delete();
    upd_mask = '0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      upd_mask[i] = last_upd;
    end
    chk("seq_req_count", 32'(req_log.size()), 32'd3);
    chk("seq_addr0", req_log[0], 32'h0);
    chk("seq_addr1", req_log[1], 32'h4);
    chk("seq_addr2", req_log[2], 32'h8);
    chk("seq_upd_every_3rd", 32'(upd_mask), 32'b1_0010_0100);
    cycle();
    chk("seq_fetch_cnt", fetch_cnt, 32'd3);

    // Random stalls, latencies and redirects.
    rand_mode = 1;
    repeat (3000) cycle();

    // Reset while a memory access is outstanding.
    k = 0;
    while (!pend && k < 50) begin
      cycle();
      k++;
    end
    chk("found_outstanding_req", 32'(pend), 32'd1);
    do_reset(1'b1);
    repeat (600) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
